// File: rtl/mem_access_ctrl.sv
// Request-side controller for the 8x8 memory: single-word writes and burst reads,
// one access outstanding at a time, read words returned over a valid/ready channel.
module mem_access_ctrl #(
    parameter int READ_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [2:0] req_len,
    output logic       wr_done,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_last,
    output logic       mem_op,
    output logic       mem_select,
    output logic [2:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          we;
    logic [2:0]    cur_addr;
    logic [2:0]    beats_left;
    logic [7:0]    wdata;
    logic [CW-1:0] lat_cnt;

    // Gated by rst so nothing can be accepted while reset is held.
    assign req_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            we         <= 1'b0;
            cur_addr   <= '0;
            beats_left <= '0;
            wdata      <= '0;
            lat_cnt    <= '0;
            mem_select <= 1'b0;
            mem_op     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_last   <= 1'b0;
            rsp_data   <= '0;
            wr_done    <= 1'b0;
        end else begin
            mem_select <= 1'b0;
            wr_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we         <= req_we;
                        cur_addr   <= req_addr;
                        wdata      <= req_wdata;
                        beats_left <= req_len;
                        mem_select <= 1'b1;
                        mem_op     <= req_we;
                        mem_addr   <= req_addr;
                        mem_wdata  <= req_wdata;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we) begin
                        wr_done <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        lat_cnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // lat_cnt is 0 in the first cycle after ISSUE, so READ_LAT-1 marks cycle T+READ_LAT.
                    if (lat_cnt == CW'(READ_LAT - 1)) begin
                        rsp_data  <= mem_rdata;
                        rsp_last  <= (beats_left == 3'd0);
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            state <= IDLE;
                        end else begin
                            cur_addr   <= cur_addr + 3'd1;
                            beats_left <= beats_left - 3'd1;
                            mem_select <= 1'b1;
                            mem_op     <= 1'b0;
                            mem_addr   <= cur_addr + 3'd1;
                            mem_wdata  <= wdata;
                            state      <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a latency-accurate memory model, expected
// accesses and read beats queued at stimulus time and popped as the DUT produces them.
module tb_mem_access_ctrl;
    localparam int READ_LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [2:0] req_addr = '0, req_len = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, wr_done, rsp_valid, rsp_last, mem_op, mem_select;
    logic [7:0] rsp_data, mem_wdata, mem_rdata;
    logic [2:0] mem_addr;

    mem_access_ctrl #(.READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .wr_done(wr_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .mem_op(mem_op),
        .mem_select(mem_select), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, sel_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: select sampled at edge, word valid READ_LAT cycles later, else poison.
    logic [7:0] mem [8];
    logic [7:0] exp_mem [8];
    logic [READ_LAT:1] vpipe = '0;
    logic [2:0] apipe [1:READ_LAT];
    initial for (int i = 0; i < 8; i++) begin
        mem[i] = 8'(i * 8'h11);
        exp_mem[i] = 8'(i * 8'h11);
        apipe[(i % READ_LAT) + 1] = '0;
    end
    always @(posedge clk) begin
        if (mem_select && mem_op) mem[mem_addr] <= mem_wdata;
        vpipe[1] <= mem_select && !mem_op;
        apipe[1] <= mem_addr;
        for (int i = 2; i <= READ_LAT; i++) begin
            vpipe[i] <= vpipe[i-1];
            apipe[i] <= apipe[i-1];
        end
    end
    assign mem_rdata = vpipe[READ_LAT] ? mem[apipe[READ_LAT]] : 8'hEE;

    logic [11:0] acc_q [$];
    logic [8:0]  rsp_q [$];
    logic        hold = 1'b0;
    logic [8:0]  held = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_select) begin
                sel_cnt++;
                if (acc_q.size() == 0) chk("extra_select", 1, 0);
                else chk("mem_access", {mem_op, mem_addr, mem_wdata}, acc_q.pop_front());
            end
            if (hold) chk("rsp_hold", {rsp_valid, rsp_last, rsp_data}, {1'b1, held});
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) chk("extra_rsp", 1, 0);
                else chk("rsp_beat", {rsp_last, rsp_data}, rsp_q.pop_front());
            end
            hold = rsp_valid && !rsp_ready;
            held = {rsp_last, rsp_data};
        end else begin
            hold = 1'b0;
        end
    end

    task automatic send(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                        input logic [2:0] len);
        int n;
        logic [2:0] a;
        if (we) begin
            acc_q.push_back({1'b1, addr, wd});
            exp_mem[addr] = wd;
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                a = addr + 3'(i);
                acc_q.push_back({1'b0, a, wd});
                rsp_q.push_back({(i == int'(len)), exp_mem[a]});
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_len = len;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        if (!req_ready) chk("req_accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((acc_q.size() != 0 || rsp_q.size() != 0 || !req_ready) && n < 300) begin
            @(negedge clk); n++;
        end
        chk("drain_queues", acc_q.size() + rsp_q.size(), 0);
        chk("drain_idle", req_ready, 1);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        if (!rsp_valid) chk(tag, 0, 1);
    endtask

    initial begin
        int n, s0;
        // Reset state, and a request presented during reset must be ignored.
        #12;
        chk("rst_outs", {req_ready, mem_select, mem_op, mem_addr, mem_wdata, rsp_valid,
                         rsp_last, rsp_data, wr_done}, 0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd7; req_wdata = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", req_ready, 1);
        repeat (4) @(negedge clk);
        chk("no_sel_after_rst", sel_cnt, 0);

        // Single write with wr_done timing.
        send(1'b1, 3'd5, 8'hA5, 3'd0);
        @(negedge clk);
        chk("wr_sel_cycle", {mem_select, wr_done, req_ready}, 3'b100);
        @(negedge clk);
        chk("wr_done_cycle", {mem_select, wr_done, req_ready}, 3'b011);
        @(negedge clk);
        chk("wr_done_pulse", wr_done, 0);

        // Single read, first-word latency.
        send(1'b0, 3'd3, 8'h00, 3'd0);
        wait_valid("rd_valid_timeout", n);
        chk("rd_latency", n, READ_LAT + 2);
        wait_done();

        // Wrap burst 6,7,0,1 with rsp_ready high: four beats at the nominal period.
        send(1'b0, 3'd6, 8'h00, 3'd3);
        n = 0;
        while (!(rsp_valid && rsp_last) && n < 60) begin @(negedge clk); n++; end
        chk("burst_period", n, 4 * (READ_LAT + 2));
        wait_done();

        // Back-to-back writes, then read them back.
        send(1'b1, 3'd1, 8'h3C, 3'd0);
        send(1'b1, 3'd2, 8'hC3, 3'd0);
        wait_done();
        send(1'b0, 3'd5, 8'h00, 3'd0);
        send(1'b0, 3'd0, 8'h5A, 3'd2);
        wait_done();

        // Backpressure on beat 2 for 10 cycles.
        rsp_ready = 1'b0;
        send(1'b0, 3'd2, 8'h00, 3'd3);
        wait_valid("bp_beat1_timeout", n);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        wait_valid("bp_beat2_timeout", n);
        s0 = sel_cnt;
        repeat (10) begin
            @(negedge clk);
            chk("bp_state", {req_ready, mem_select, rsp_valid}, 3'b001);
        end
        chk("bp_no_select", sel_cnt - s0, 0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_done();

        // Full burst with random backpressure.
        send(1'b0, 3'd4, 8'h00, 3'd7);
        n = 0;
        while ((acc_q.size() != 0 || rsp_q.size() != 0) && n < 400) begin
            @(posedge clk); #1 rsp_ready = 1'($urandom_range(0, 1)); n++;
        end
        rsp_ready = 1'b1;
        wait_done();

        // Abort during WAIT of beat 2 of an 8-beat burst.
        s0 = sel_cnt;
        send(1'b0, 3'd0, 8'h00, 3'd7);
        n = 0;
        while (sel_cnt < s0 + 2 && n < 40) begin @(posedge clk); #1; n++; end
        chk("abort_reach_beat2", sel_cnt - s0, 2);
        #2;
        chk("abort_in_wait", {mem_select, rsp_valid}, 0);
        rst = 1'b1;
        #1;
        chk("abort_outs", {req_ready, mem_select, rsp_valid, wr_done}, 0);
        acc_q.delete();
        rsp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        s0 = sel_cnt;
        repeat (12) begin
            @(negedge clk);
            chk("abort_quiet", {rsp_valid, req_ready}, 2'b01);
        end
        chk("abort_no_select", sel_cnt - s0, 0);
        send(1'b0, 3'd7, 8'h00, 3'd0);
        wait_valid("post_abort_timeout", n);
        chk("post_abort_latency", n, READ_LAT + 2);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
